// File: rtl/nco_phase_inc_sweep.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nco_phase_inc_sweep                                          |
// | Description : Linear phase-increment sweep generator feeding an NCO.       |
// |               Optional triangular repeat mode: NCO_SWEEP_LOOP_EN           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nco_phase_inc_sweep #(
    parameter int APR     = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clken,
    input  logic               start,
    input  logic               abort,
    input  logic [APR-1:0]     f_start,
    input  logic [APR-1:0]     f_stop,
    input  logic [APR-1:0]     f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [APR-1:0]     phi_inc_o,
    output logic               phi_upd_o,
    output logic               clken_o,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DWELL  = 2'd1,
        S_STEP   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [APR-1:0]     phi_q, phi_d;
    logic               upd_q, upd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dir_q, dir_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [APR-1:0]     tgt_q, tgt_d;
    logic [APR-1:0]     step_q, step_d;
`ifdef NCO_SWEEP_LOOP_EN
    logic [APR-1:0]     org_q, org_d;
`endif

    logic [APR:0]       sum_up;
    logic [APR:0]       sum_dn;
    logic [APR-1:0]     next_val;

    // One extra bit catches carry/borrow so the clamp can never be bypassed by wrap.
    always_comb begin
        sum_up = {1'b0, phi_q} + {1'b0, step_q};
        sum_dn = {1'b0, phi_q} - {1'b0, step_q};
        if (step_q == '0) begin
            next_val = tgt_q;
        end else if (!dir_q) begin
            next_val = (sum_up > {1'b0, tgt_q}) ? tgt_q : sum_up[APR-1:0];
        end else begin
            next_val = (sum_dn[APR] || (sum_dn[APR-1:0] < tgt_q)) ? tgt_q : sum_dn[APR-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        phi_d   = phi_q;
        upd_d   = upd_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
`ifdef NCO_SWEEP_LOOP_EN
        org_d   = org_q;
`endif
        if (clken) begin
            upd_d  = 1'b0;
            done_d = 1'b0;
            if (state_q == S_IDLE) begin
                if (start && !abort) begin
                    phi_d   = f_start;
                    upd_d   = 1'b1;
                    busy_d  = 1'b1;
                    dir_d   = (f_stop < f_start);
                    cnt_d   = dwell;
                    dwell_d = dwell;
                    tgt_d   = f_stop;
                    step_d  = f_step;
`ifdef NCO_SWEEP_LOOP_EN
                    org_d   = f_start;
`endif
                    state_d = S_DWELL;
                end
            end else if (abort) begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_DWELL: begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 1'b1;
                        end else if (phi_q == tgt_q) begin
`ifdef NCO_SWEEP_LOOP_EN
                            tgt_d   = org_q;
                            org_d   = tgt_q;
                            dir_d   = ~dir_q;
                            state_d = S_STEP;
`else
                            state_d = S_FINISH;
`endif
                        end else begin
                            state_d = S_STEP;
                        end
                    end
                    S_STEP: begin
                        phi_d   = next_val;
                        upd_d   = 1'b1;
                        cnt_d   = dwell_q;
                        state_d = S_DWELL;
                    end
                    S_FINISH: begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            phi_q   <= '0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
`ifdef NCO_SWEEP_LOOP_EN
            org_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            phi_q   <= phi_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
`ifdef NCO_SWEEP_LOOP_EN
            org_q   <= org_d;
`endif
        end
    end

    assign phi_inc_o = phi_q;
    assign phi_upd_o = upd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign clken_o   = clken;

endmodule
`default_nettype wire

// File: tb/tb_nco_phase_inc_sweep.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nco_phase_inc_sweep                                       |
// | Description : Directed + randomized bench with a value-list sweep model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_nco_phase_inc_sweep;

`ifdef NCO_SWEEP_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        clken;
    logic        start;
    logic        abort;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_step;
    logic [15:0] dwell;
    logic [31:0] phi_inc_o;
    logic        phi_upd_o;
    logic        clken_o;
    logic        busy;
    logic        done;

    nco_phase_inc_sweep #(.APR(32), .DWELL_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .start     (start),
        .abort     (abort),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .phi_inc_o (phi_inc_o),
        .phi_upd_o (phi_upd_o),
        .clken_o   (clken_o),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the whole sweep is expanded into its list of values up front;
    // outputs then follow from how many enabled edges have passed since the start.
    bit          m_valid  = 1'b0;
    bit          m_active = 1'b0;
    int          m_k;
    int          m_d;
    logic [31:0] m_vals[$];
    logic [31:0] m_phi;
    logic        m_upd, m_busy, m_done;

    function automatic logic [31:0] stepv(input logic [31:0] v, input logic [31:0] tgt,
                                          input logic [31:0] st);
        if (st == 0) return tgt;
        if (tgt > v) return (tgt - v <= st) ? tgt : v + st;
        return (v - tgt <= st) ? tgt : v - st;
    endfunction

    task automatic build(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st);
        logic [31:0] v, tgt, oth, tmp;
        m_vals.delete();
        v = fs; tgt = fe; oth = fs;
        m_vals.push_back(v);
        if (LOOP) begin
            repeat (2500) begin
                if (v == tgt) begin tmp = tgt; tgt = oth; oth = tmp; end
                v = stepv(v, tgt, st);
                m_vals.push_back(v);
            end
        end else begin
            while (v != fe) begin
                v = stepv(v, fe, st);
                m_vals.push_back(v);
            end
        end
    endtask

    task automatic eval();
        int p, n, idx;
        p = m_d + 2;
        n = m_vals.size();
        if (!LOOP && m_k == n * p) begin
            m_phi = m_vals[n-1]; m_upd = 1'b0; m_busy = 1'b0; m_done = 1'b1;
            m_active = 1'b0;
        end else begin
            idx = m_k / p;
            if (idx >= n) idx = n - 1;
            m_phi = m_vals[idx]; m_upd = (m_k % p == 0); m_busy = 1'b1; m_done = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            m_valid = 1'b1; m_active = 1'b0;
            m_phi = 32'h0; m_upd = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else if (m_valid && clken) begin
            if (m_active) begin
                if (abort) begin
                    m_active = 1'b0; m_busy = 1'b0; m_upd = 1'b0; m_done = 1'b0;
                end else begin
                    m_k++;
                    eval();
                end
            end else begin
                m_upd = 1'b0; m_done = 1'b0;
                if (start && !abort) begin
                    build(f_start, f_stop, f_step);
                    m_d = int'(dwell);
                    m_k = 0;
                    m_active = 1'b1;
                    eval();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("phi_inc_o", phi_inc_o, m_phi);
            check("phi_upd_o", 32'(phi_upd_o), 32'(m_upd));
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("clken_o", 32'(clken_o), 32'(clken));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic go(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                      input logic [15:0] dw);
        f_start = fs; f_stop = fe; f_step = st; dwell = dw;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] base;
        reset_n = 1'b0; clken = 1'b1; start = 1'b0; abort = 1'b0;
        f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
        ticks(2);
        check("rst_phi", phi_inc_o, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_upd", 32'(phi_upd_o), 32'h0);
        reset_n = 1'b1;
        tick();

`ifndef NCO_SWEEP_LOOP_EN
        go(32'd100, 32'd130, 32'd10, 16'd2);
        check("up_e0_phi", phi_inc_o, 32'd100);
        check("up_e0_upd", 32'(phi_upd_o), 32'h1);
        ticks(3); check("up_e3_phi", phi_inc_o, 32'd100);
        ticks(1); check("up_e4_phi", phi_inc_o, 32'd110);
        ticks(4); check("up_e8_phi", phi_inc_o, 32'd120);
        ticks(4); check("up_e12_phi", phi_inc_o, 32'd130);
        ticks(3); check("up_e15_done", 32'(done), 32'h0);
        ticks(1); check("up_e16_done", 32'(done), 32'h1);
        check("up_e16_busy", 32'(busy), 32'h0);
        ticks(1); check("up_e17_done", 32'(done), 32'h0);
        check("up_hold_phi", phi_inc_o, 32'd130);
        ticks(2);

        go(32'd50, 32'd5, 32'd20, 16'd0);
        check("dn_e0", phi_inc_o, 32'd50);
        ticks(2); check("dn_e2", phi_inc_o, 32'd30);
        ticks(2); check("dn_e4", phi_inc_o, 32'd10);
        ticks(2); check("dn_e6", phi_inc_o, 32'd5);
        ticks(2); check("dn_done", 32'(done), 32'h1);
        ticks(2);

        go(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1);
        ticks(3); check("carry_clamp", phi_inc_o, 32'hFFFF_FFFF);
        ticks(3); check("carry_done", 32'(done), 32'h1);
        ticks(2);

        go(32'd100, 32'd130, 32'd10, 16'd2);
        ticks(4);
        start = 1'b1; abort = 1'b1; f_start = 32'd7;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_phi", phi_inc_o, 32'd110);
        ticks(20);
        check("abort_hold", phi_inc_o, 32'd110);

        go(32'd100, 32'd130, 32'd10, 16'd2);
        ticks(2);
        start = 1'b1; f_start = 32'd999; dwell = 16'd0;
        tick();
        start = 1'b0;
        tick(); check("busy_start_ign", phi_inc_o, 32'd110);
        tick();
        clken = 1'b0;
        ticks(5); check("clken_freeze", phi_inc_o, 32'd110);
        clken = 1'b1;
        ticks(3); check("clken_resume", phi_inc_o, 32'd120);
        abort = 1'b1; tick(); abort = 1'b0; tick();
`else
        go(32'd100, 32'd130, 32'd10, 16'd2);
        check("loop_e0", phi_inc_o, 32'd100);
        ticks(4);  check("loop_e4", phi_inc_o, 32'd110);
        ticks(4);  check("loop_e8", phi_inc_o, 32'd120);
        ticks(4);  check("loop_e12", phi_inc_o, 32'd130);
        ticks(4);  check("loop_e16", phi_inc_o, 32'd120);
        ticks(4);  check("loop_e20", phi_inc_o, 32'd110);
        ticks(4);  check("loop_e24", phi_inc_o, 32'd100);
        ticks(4);  check("loop_e28", phi_inc_o, 32'd110);
        ticks(4);  check("loop_e32", phi_inc_o, 32'd120);
        check("loop_busy", 32'(busy), 32'h1);
        check("loop_done", 32'(done), 32'h0);
        abort = 1'b1; tick(); abort = 1'b0; tick();
`endif

        for (int i = 0; i < 4000; i++) begin
            reset_n = ($urandom_range(199) != 0);
            clken   = ($urandom_range(7) != 0);
            start   = ($urandom_range(15) == 0);
            abort   = ($urandom_range(49) == 0);
            base    = ($urandom_range(3) == 0) ? 32'hFFFF_FE70 : 32'h0;
            f_start = base + 32'($urandom_range(399));
            f_stop  = base + 32'($urandom_range(399));
            case ($urandom_range(7))
                0:       f_step = 32'h0;
                1:       f_step = 32'hFFFF_FF00;
                default: f_step = 32'($urandom_range(1, 70));
            endcase
            dwell = 16'($urandom_range(3));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
